uart_tx_stage: RTL and testbench
================================

// Module: uart_tx_stage
// PURPOSE
//   Output stage downstream of the core logic in tt_um_JOSEBPSWKS. Accepts bytes over a valid/ready
//   handshake, buffers them in a small FIFO and serialises them as 8N1 UART on one uio pin.
//   Lets the core emit result bytes in bursts without stalling on serial timing.
// PARAMETERS
//   CLKS_PER_BIT  87  clocks per UART bit (10 MHz / 115200); legal range 2..1023
//   FIFO_DEPTH    4   buffer entries; power of two, 2..16
// PORTS
//   clk         in   1              single clock; every flop is on its rising edge
//   rst         in   1              asynchronous, active-high reset (top drives rst = ~rst_n)
//   in_valid    in   1              producer presents in_data
//   in_data     in   8              byte to transmit
//   in_ready    out  1              FIFO can accept a byte this cycle
//   tx          out  1              UART serial line; idles high
//   busy        out  1              a frame is on the line, or the FIFO is non-empty
//   fifo_count  out  $clog2(D)+1    bytes currently buffered (D = FIFO_DEPTH)
//   overflow    out  1              sticky: set when in_valid is high while in_ready is low
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset values: tx=1, in_ready=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO empty.
//   Reset mid-frame: tx returns to 1 immediately (asynchronously). FIFO contents are discarded.
//   Push: in_valid && in_ready at an edge writes in_data. in_ready = (fifo_count != D), registered.
//     in_ready does NOT anticipate a same-cycle pop.
//   Dropped push: in_valid && !in_ready drops the byte and sets overflow. Only rst clears overflow.
//   Simultaneous push and pop with count > 0: count unchanged; FIFO ordering preserved.
//   FIFO read/write pointers wrap modulo D. count spans 0..D.
//   FSM states: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) runs in every state
//     except IDLE. A bit index (0..7) is used in DATA.
//   IDLE: if count != 0, pop the head into the shift register, drive tx=0, go to START.
//     Otherwise tx=1.
//   START: hold tx=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
//   DATA: tx = shift[0], sent LSB first. Each bit lasts CLKS_PER_BIT clocks.
//     After bit 7, go to STOP.
//   STOP: tx=1 for CLKS_PER_BIT clocks. On the last clock:
//     - count != 0: pop and go straight to START (no idle gap);
//     - count == 0: go to IDLE.
//   Latency: a push at edge N into an empty, idle block pops at edge N+1. tx falls after edge N+1.
//     A full frame occupies exactly 10*CLKS_PER_BIT clocks.
//   tx is driven directly from a flop (glitch-free). busy = (state != IDLE) || (count != 0).
//   in_data is sampled only on push; it may change freely at any other time.
// STRUCTURE
//   Shared header uart_defs.vh:
//     - FSM state encodings (2 bits: IDLE=0, START=1, DATA=2, STOP=3);
//     - UART_FRAME_BITS=10;
//     - a CLKS_PER_BIT helper macro computed from clock and baud.
//   Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/count, async active-high reset.
//   uart_tx_stage holds the FSM, bit timer and shift register, and the overflow flag.
// TESTING  (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1. Reset: assert rst for 3 clks -> tx=1, in_ready=1, busy=0, fifo_count=0, overflow=0.
//   2. Single byte: push 0xA5 -> tx low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each,
//      then high 4 clks. busy falls after 40 clks.
//   3. Back-to-back: push 0x00,0xFF,0x55 on consecutive clks -> three frames with no idle gap,
//      received in order. fifo_count peaks at 2.
//   4. Overflow: push 6 bytes in 6 consecutive clks while the first frame starts.
//      -> 5 bytes accepted (1 popped + 4 buffered). in_ready low on the 6th.
//      -> overflow=1; exactly 5 frames are emitted.
//   5. Reset mid-frame: assert rst during DATA bit 3 of 0x3C -> tx=1 at once, fifo_count=0.
//      No further frames after release.
//   6. Push/pop collision: FIFO holds 2 bytes, push lands on the STOP-end pop clock
//      -> fifo_count stays 2; byte order intact.

Source files
------------

// File: rtl/uart_tx_stage_pkg.sv
// Shared definitions for the UART transmit output stage: FSM encoding and bit-timing helper.
package uart_tx_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned DATA_BITS  = 8;

   // Rounded clocks-per-bit for a given core clock and baud rate.
   function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_stage_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; head word is visible on rdata while not empty.
module uart_tx_stage_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_stage.sv
// Buffered 8N1 UART transmitter: bytes arrive over valid/ready, queue in a FIFO, leave on tx.
module uart_tx_stage
   import uart_tx_stage_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = clks_per_bit(10_000_000, 115_200),
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(DATA_BITS);

   tx_state_e     state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [IW-1:0] bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          overflow_q;

   logic          push_c;
   logic          pop_c;
   logic          bit_done_c;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_head;

   assign push_c     = in_valid && !fifo_full;
   assign in_ready   = !fifo_full;
   assign bit_done_c = (bit_cnt_q == BW'(CLKS_PER_BIT - 1));
   assign tx         = tx_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;

   uart_tx_stage_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .wdata (in_data),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_q || (in_valid && fifo_full);
      end
   end

   // tx_d is the value tx will hold for the next clock; a new frame's start bit is set on the pop.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q + BW'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               shift_d = fifo_head;
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_done_c) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_done_c) begin
               bit_cnt_d = '0;
               if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
         ST_STOP: begin
            if (bit_done_c) begin
               bit_cnt_d = '0;
               if (!fifo_empty) begin
                  pop_c   = 1'b1;
                  shift_d = fifo_head;
                  tx_d    = 1'b0;
                  state_d = ST_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Bench for uart_tx_stage: directed pushes, serial-line receiver model and expected-byte scoreboard.
module tb_uart_tx_stage;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   int total = 0;
   int bad   = 0;
   int frames = 0;
   int base;
   logic [7:0] sb [$];

   uart_tx_stage #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Receiver: frame starts on the first low sample, each bit sampled mid-period on the falling edge.
   bit         rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte;
   logic [7:0] rx_exp;

   always @(negedge clk) begin
      if (rst) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (tx === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == int'(CPB / 2)) check("rx_start", 32'(tx), 32'd0);
         for (int j = 0; j < 8; j++)
            if (rx_cnt == int'(CPB * (j + 1) + CPB / 2)) rx_byte[j] = tx;
         if (rx_cnt == int'(CPB * 9 + CPB / 2)) begin
            check("rx_stop", 32'(tx), 32'd1);
            if (sb.size() == 0) begin
               check("rx_unexpected", 32'(rx_byte), 32'h100);
            end else begin
               rx_exp = sb.pop_front();
               check("rx_byte", 32'(rx_byte), 32'(rx_exp));
            end
            frames++;
            rx_act = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // 1. reset
      repeat (3) tick();
      check("rst_tx",       32'(tx),         32'd1);
      check("rst_in_ready", 32'(in_ready),   32'd1);
      check("rst_busy",     32'(busy),       32'd0);
      check("rst_count",    32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow),   32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // 2. single byte 0xA5: tx falls one edge after the push, busy drops 40 clocks after that
      base = frames;
      in_valid = 1'b1; in_data = 8'hA5; sb.push_back(8'hA5);
      tick();
      in_valid = 1'b0; in_data = 8'h3F;
      check("t2_count_push", 32'(fifo_count), 32'd1);
      check("t2_tx_idle",    32'(tx),         32'd1);
      check("t2_busy_push",  32'(busy),       32'd1);
      tick();
      check("t2_tx_start",   32'(tx),         32'd0);
      check("t2_count_pop",  32'(fifo_count), 32'd0);
      repeat (39) tick();
      check("t2_busy_stop",  32'(busy),       32'd1);
      check("t2_tx_stop",    32'(tx),         32'd1);
      tick();
      check("t2_busy_end",   32'(busy),       32'd0);
      check("t2_frames",     32'(frames),     32'(base + 1));

      // 3. back-to-back: three frames with no gap, count peaks at 2
      repeat (3) tick();
      base = frames;
      in_valid = 1'b1; in_data = 8'h00; sb.push_back(8'h00);
      tick();
      check("t3_count1", 32'(fifo_count), 32'd1);
      in_data = 8'hFF; sb.push_back(8'hFF);
      tick();
      check("t3_count2", 32'(fifo_count), 32'd1);
      in_data = 8'h55; sb.push_back(8'h55);
      tick();
      in_valid = 1'b0;
      check("t3_count3", 32'(fifo_count), 32'd2);
      repeat (118) tick();
      check("t3_busy_last", 32'(busy), 32'd1);
      tick();
      check("t3_busy_end",  32'(busy), 32'd0);
      check("t3_frames",    32'(frames), 32'(base + 3));

      // 4. overflow: six pushes on consecutive clocks, the sixth is dropped
      repeat (3) tick();
      base = frames;
      for (int i = 0; i < 6; i++) begin
         check("t4_ready", 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
         in_valid = 1'b1;
         in_data  = 8'(8'h10 + 8'(i) * 8'h11);
         if (i < 5) sb.push_back(in_data);
         tick();
      end
      in_valid = 1'b0;
      check("t4_overflow", 32'(overflow),   32'd1);
      check("t4_count",    32'(fifo_count), 32'd4);
      repeat (200) tick();
      check("t4_busy_end",  32'(busy),     32'd0);
      check("t4_frames",    32'(frames),   32'(base + 5));
      check("t4_sticky",    32'(overflow), 32'd1);

      // 5. reset during data bit 3 of 0x3C with a second byte queued
      repeat (3) tick();
      base = frames;
      in_valid = 1'b1; in_data = 8'h3C;
      tick();
      in_data = 8'h11;
      tick();
      in_valid = 1'b0;
      repeat (17) tick();
      check("t5_count_pre", 32'(fifo_count), 32'd1);
      check("t5_busy_pre",  32'(busy),       32'd1);
      rst = 1'b1;
      #1;
      check("t5_tx",       32'(tx),         32'd1);
      check("t5_count",    32'(fifo_count), 32'd0);
      check("t5_busy",     32'(busy),       32'd0);
      check("t5_overflow", 32'(overflow),   32'd0);
      tick();
      rst = 1'b0;
      repeat (60) tick();
      check("t5_frames",   32'(frames), 32'(base));
      check("t5_tx_idle",  32'(tx),     32'd1);
      check("t5_busy_end", 32'(busy),   32'd0);

      // 6. push on the same clock as the end-of-stop pop: count holds, order kept
      base = frames;
      in_valid = 1'b1; in_data = 8'h96; sb.push_back(8'h96);
      tick();
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1; in_data = 8'h4B; sb.push_back(8'h4B);
      tick();
      in_data = 8'hE1; sb.push_back(8'hE1);
      tick();
      in_valid = 1'b0;
      check("t6_count_pre", 32'(fifo_count), 32'd2);
      repeat (37) tick();
      in_valid = 1'b1; in_data = 8'h7E; sb.push_back(8'h7E);
      tick();
      in_valid = 1'b0;
      check("t6_count_coll", 32'(fifo_count), 32'd2);
      repeat (125) tick();
      check("t6_busy_end", 32'(busy),      32'd0);
      check("t6_frames",   32'(frames),    32'(base + 4));
      check("t6_sb_left",  32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
